// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger ADC sequencer: channel codes,
// FSM state type, accumulator width and round-robin channel picker.
package batcharger_pkg;

    localparam logic [1:0] CH_V = 2'b00;
    localparam logic [1:0] CH_I = 2'b01;
    localparam logic [1:0] CH_T = 2'b10;

    localparam int ACC_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        STORE   = 2'd3
    } state_t;

    // First enabled channel after 'last' in V->I->T->V order; 'last' itself wins only if alone.
    function automatic logic [1:0] next_channel(input logic [1:0] last, input logic [2:0] mon);
        logic [1:0] c;
        logic [1:0] r;
        logic       found;
        c     = last;
        r     = CH_V;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = (c == CH_T) ? CH_V : c + 2'd1;
            if (!found && mon[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/batcharger_adc_sequencer_if.sv
// ADC handshake bundle: mux select and start pulse out, end-of-conversion and data back.
interface batcharger_adc_sequencer_if;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_eoc;
    logic [7:0] adc_data;

    modport master (output adc_sel, adc_start, input adc_eoc, adc_data);
    modport slave  (input adc_sel, adc_start, output adc_eoc, adc_data);
endinterface

// File: rtl/batcharger_adc_avg.sv
// Four-sample boxcar for one channel; publishes sum>>2 combinationally on the
// fourth sample so the caller's result register updates on the same edge.
module batcharger_adc_avg
    import batcharger_pkg::*;
(
    input  logic       clk,
    input  logic       rstz,
    input  logic       clr,
    input  logic       smp_vld,
    input  logic [7:0] smp_data,
    output logic       pub,
    output logic [7:0] pub_data
);

    logic [ACC_W-1:0] sum_reg;
    logic [ACC_W-1:0] sum_next;
    logic [1:0]       cnt_reg;

    assign sum_next = sum_reg + ACC_W'(smp_data);
    assign pub      = smp_vld && (cnt_reg == 2'd3);
    assign pub_data = sum_next[ACC_W-1:2];

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sum_reg <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            sum_reg <= '0;
            cnt_reg <= '0;
        end else if (smp_vld) begin
            sum_reg <= (cnt_reg == 2'd3) ? '0 : sum_next;
            cnt_reg <= cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/batcharger_adc_sequencer.sv
// Round-robin V/I/T ADC sequencer with mux settle, conversion timeout and
// per-channel result registers. Define BATCHARGER_ADC_AVG_EN for 4-sample averaging.
module batcharger_adc_sequencer
    import batcharger_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                clk,
    input  logic                                rstz,
    input  logic                                en,
    input  logic                                vmonen,
    input  logic                                imonen,
    input  logic                                tmonen,
    batcharger_adc_sequencer_if.master          adc,
    output logic [7:0]                          vbat,
    output logic [7:0]                          ibat,
    output logic [7:0]                          tbat,
    output logic                                vtok,
    output logic                                adc_err
);

    state_t     state_reg;
    logic [1:0] sel_reg;
    logic [1:0] last_ch_reg;
    logic       start_reg;
    logic [7:0] cnt_reg;
    logic [7:0] data_reg;
    logic       ok_reg;
    logic       err_reg;
    logic       vtok_reg;

    logic [2:0] mon;
    logic       any_en;
    logic       ch_en;
    logic [1:0] nxt_ch;
    logic       store_pub;
    logic [2:0] valid_vec;
    logic [7:0] res_vec [3];

    assign mon       = {tmonen, imonen, vmonen};
    assign any_en    = |mon;
    assign ch_en     = mon[sel_reg];
    assign nxt_ch    = next_channel(last_ch_reg, mon);
    // ok_reg drops if the channel was disabled at any point, or on timeout
    assign store_pub = (state_reg == STORE) && en && ok_reg && ch_en;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_reg   <= IDLE;
            sel_reg     <= CH_V;
            last_ch_reg <= CH_T;
            start_reg   <= 1'b0;
            cnt_reg     <= '0;
            data_reg    <= '0;
            ok_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else if (!en) begin
            state_reg   <= IDLE;
            last_ch_reg <= CH_T;
            start_reg   <= 1'b0;
            ok_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, STORE: begin
                    if (any_en) begin
                        sel_reg     <= nxt_ch;
                        last_ch_reg <= nxt_ch;
                        cnt_reg     <= 8'(SETTLE_CYC - 1);
                        ok_reg      <= 1'b1;
                        state_reg   <= SETTLE;
                    end else begin
                        state_reg   <= IDLE;
                    end
                end
                SETTLE: begin
                    if (!ch_en) ok_reg <= 1'b0;
                    if (cnt_reg == 8'd0) begin
                        start_reg <= 1'b1;
                        state_reg <= CONVERT;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                CONVERT: begin
                    start_reg <= 1'b0;
                    if (!ch_en) ok_reg <= 1'b0;
                    // eoc during the start cycle belongs to no conversion of ours
                    if (!start_reg && adc.adc_eoc) begin
                        data_reg  <= adc.adc_data;
                        state_reg <= STORE;
                    end else if (cnt_reg == 8'(TIMEOUT_CYC - 1)) begin
                        err_reg   <= 1'b1;
                        ok_reg    <= 1'b0;
                        state_reg <= STORE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic       clr;
            logic       smp;
            logic       pub;
            logic [7:0] pub_data;
            logic [7:0] res_reg;
            logic       valid_reg;

            assign clr = !en || !mon[gi];
            assign smp = store_pub && (sel_reg == 2'(gi));

`ifdef BATCHARGER_ADC_AVG_EN
            batcharger_adc_avg u_avg (
                .clk      (clk),
                .rstz     (rstz),
                .clr      (clr),
                .smp_vld  (smp),
                .smp_data (data_reg),
                .pub      (pub),
                .pub_data (pub_data)
            );
`else
            assign pub      = smp;
            assign pub_data = data_reg;
`endif

            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    res_reg   <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    if (pub) res_reg <= pub_data;
                    if (clr)      valid_reg <= 1'b0;
                    else if (pub) valid_reg <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign res_vec[gi]   = res_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) vtok_reg <= 1'b0;
        else       vtok_reg <= valid_vec[CH_V] & valid_vec[CH_T];
    end

    assign adc.adc_sel   = sel_reg;
    assign adc.adc_start = start_reg;
    assign vbat          = res_vec[CH_V];
    assign ibat          = res_vec[CH_I];
    assign tbat          = res_vec[CH_T];
    assign vtok          = vtok_reg;
    assign adc_err       = err_reg;

endmodule

// File: doc/batcharger_adc_sequencer.md
BATCHARGER_ADC_SEQUENCER -- requirements
Module: batcharger_adc_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, 4, mux-settle cycles between channel select and conversion start (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, 64, maximum cycles from adc_start to adc_eoc (2..255).
REQ-003 SHALL have port clk  input  1  clock; reset rstz, asynchronous, active-low; clock clk.
REQ-004 SHALL have port rstz  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  sequencer enable.
REQ-006 SHALL have ports vmonen, imonen, tmonen  input  1 each  per-channel monitor enables from the charger controller.
REQ-007 SHALL have port adc_sel  output  2  analog mux select: 00 = V, 01 = I, 10 = T.
REQ-008 SHALL have port adc_start  output  1  one-cycle conversion start pulse.
REQ-009 SHALL have ports adc_eoc  input  1  end of conversion, and adc_data  input  8  conversion result valid with adc_eoc.
REQ-010 SHALL have ports vbat, ibat, tbat  output  8 each  registered channel results.
REQ-011 SHALL have port vtok  output  1  voltage and temperature values valid.
REQ-012 SHALL have port adc_err  output  1  sticky conversion-timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, CONVERT, STORE.
REQ-014 Channel order SHALL be V->I->T->V, skipping channels whose monen is low; the next channel SHALL be chosen in IDLE/STORE from the current enables.
REQ-015 IDLE->SETTLE SHALL occur when en=1 and at least one monen=1; otherwise the FSM SHALL stay in IDLE.
REQ-016 SETTLE SHALL drive adc_sel and last exactly SETTLE_CYC cycles, then go to CONVERT.
REQ-017 adc_start SHALL pulse high for the first CONVERT cycle only.
REQ-018 In CONVERT, adc_eoc=1 SHALL capture adc_data and move to STORE; adc_eoc in the start cycle SHALL be ignored.
REQ-019 If adc_eoc has not arrived TIMEOUT_CYC cycles after adc_start, the sample SHALL be discarded, adc_err SHALL be set, and the FSM SHALL go to STORE without updating any output.
REQ-020 STORE SHALL last one cycle; the result register SHALL update on the STORE clock edge, one cycle after the eoc edge.
REQ-021 Per-channel valid flags SHALL set on the first result update and clear when en=0 or their monen=0.
REQ-022 vtok SHALL equal the registered AND of the V valid and T valid flags.
REQ-023 adc_err SHALL clear only while en=0 or on reset.
REQ-024 Deassertion of en in any state SHALL return the FSM to IDLE on the next edge, abort any conversion without updating results, and leave vbat/ibat/tbat holding their values.
REQ-025 A monen dropping mid-conversion SHALL let the conversion finish but SHALL discard its result.

Reset
REQ-026 rstz low SHALL asynchronously force: FSM = IDLE; adc_sel = 00; adc_start, vtok, adc_err = 0; vbat, ibat, tbat = 0; valid flags, counters and accumulators = 0.

Configuration
REQ-027 With BATCHARGER_ADC_AVG_EN defined, each channel SHALL accumulate 4 consecutive samples in a 10-bit sum and publish sum>>2 (truncated) on every 4th sample; the valid flag SHALL set only on that publish.
REQ-028 With the macro undefined, each sample SHALL be published directly and no accumulator logic SHALL exist.

Structure
REQ-029 Package batcharger_pkg SHALL hold the channel encodings (CH_V, CH_I, CH_T), the FSM state typedef, and the accumulator width constant.
REQ-030 Averaging SHALL live in sub-module batcharger_adc_avg, instantiated once per channel only under BATCHARGER_ADC_AVG_EN.

Verification
REQ-031 All monen = 1, SETTLE_CYC = 4, eoc 10 cycles after start with data 0x93/0x20/0x80 -> vbat = 0x93, ibat = 0x20, tbat = 0x80 in order; vtok rises after the tbat update.
REQ-032 Only imonen = 1 -> adc_sel stays 01; vtok stays 0.
REQ-033 adc_eoc withheld -> adc_err = 1 on cycle TIMEOUT_CYC after start; outputs unchanged; sequence moves to the next channel; en = 0 clears adc_err.
REQ-034 en dropped during CONVERT, then a late eoc with 0xFF -> FSM in IDLE; vbat unchanged; vtok = 0.
REQ-035 With AVG_EN, V samples 0x10, 0x11, 0x12, 0x13 -> vbat = 0x11 after the 4th sample only.
REQ-036 rstz pulsed mid-SETTLE -> all outputs 0 immediately, asynchronously.
